// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian 32-bit words into 512-bit blocks,
// appends the 0x80 marker, zero fill and the 64-bit bit length.
module sha256_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    in_data,
  input  logic           in_last,
  input  logic [1:0]     in_bytes,
  output logic           blk_valid,
  input  logic           blk_ready,
  output logic [511:0]   blk_data,
  output logic           blk_first,
  output logic           blk_last
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned NWORDS = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic [1:0] {
    S_FILL,
    S_PAD,
    S_EMIT
  } state_e;

  state_e                          state_q, state_d;
  logic [IDX_W-1:0]                widx_q, widx_d;
  logic [NWORDS-1:0][WORD_W-1:0]   buf_q, buf_d;
  logic [LEN_W-1:0]                msg_bits_q, msg_bits_d;
  logic                            pad_pend_q, pad_pend_d;
  logic                            final_blk_q, final_blk_d;
  logic                            first_blk_q, first_blk_d;
  // A non-final block was emitted and a continuation block is still needed.
  logic                            pad_owed_q, pad_owed_d;
  // High-half of the length has been written; low half goes into slot 15 next.
  logic                            len_lo_q, len_lo_d;
  logic [WORD_W-1:0]               last_word;

  // Word 0 sits in the top bits of the block, so slot i maps to packed index 15-i.
  always_comb begin
    state_d     = state_q;
    widx_d      = widx_q;
    buf_d       = buf_q;
    msg_bits_d  = msg_bits_q;
    pad_pend_d  = pad_pend_q;
    final_blk_d = final_blk_q;
    first_blk_d = first_blk_q;
    pad_owed_d  = pad_owed_q;
    len_lo_d    = len_lo_q;

    case (in_bytes)
      2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
      2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
      2'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase

    case (state_q)
      S_FILL: begin
        if (in_valid) begin
          widx_d = widx_q + IDX_W'(1);
          if (!in_last) begin
            buf_d[~widx_q] = in_data;
            msg_bits_d     = msg_bits_q + LEN_W'(32);
            if (widx_q == IDX_W'(15)) begin
              state_d     = S_EMIT;
              final_blk_d = 1'b0;
            end
          end else begin
            buf_d[~widx_q] = last_word;
            pad_pend_d     = (in_bytes == 2'd0);
            if (in_bytes == 2'd0) begin
              msg_bits_d = msg_bits_q + LEN_W'(32);
            end else begin
              msg_bits_d = msg_bits_q + LEN_W'({in_bytes, 3'b000});
            end
            // A last word in slot 15 fills the block; all padding goes to a continuation.
            if (widx_q == IDX_W'(15)) begin
              state_d     = S_EMIT;
              final_blk_d = 1'b0;
              pad_owed_d  = 1'b1;
            end else begin
              state_d = S_PAD;
            end
          end
        end
      end

      S_PAD: begin
        widx_d = widx_q + IDX_W'(1);
        if (len_lo_q) begin
          buf_d[~widx_q] = msg_bits_q[31:0];
          len_lo_d       = 1'b0;
          state_d        = S_EMIT;
          final_blk_d    = 1'b1;
        end else if ((widx_q == IDX_W'(14)) && !pad_pend_q) begin
          buf_d[~widx_q] = msg_bits_q[LEN_W-1 -: 32];
          len_lo_d       = 1'b1;
        end else begin
          buf_d[~widx_q] = pad_pend_q ? 32'h8000_0000 : 32'h0000_0000;
          pad_pend_d     = 1'b0;
          if (widx_q == IDX_W'(15)) begin
            state_d     = S_EMIT;
            final_blk_d = 1'b0;
            pad_owed_d  = 1'b1;
          end
        end
      end

      S_EMIT: begin
        if (blk_ready) begin
          buf_d  = '0;
          widx_d = '0;
          if (final_blk_q) begin
            state_d     = S_FILL;
            msg_bits_d  = '0;
            first_blk_d = 1'b1;
            final_blk_d = 1'b0;
          end else if (pad_owed_q) begin
            state_d     = S_PAD;
            pad_owed_d  = 1'b0;
            first_blk_d = 1'b0;
          end else begin
            state_d     = S_FILL;
            first_blk_d = 1'b0;
          end
        end
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FILL;
      widx_q      <= '0;
      buf_q       <= '0;
      msg_bits_q  <= '0;
      pad_pend_q  <= 1'b0;
      final_blk_q <= 1'b0;
      first_blk_q <= 1'b1;
      pad_owed_q  <= 1'b0;
      len_lo_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      widx_q      <= widx_d;
      buf_q       <= buf_d;
      msg_bits_q  <= msg_bits_d;
      pad_pend_q  <= pad_pend_d;
      final_blk_q <= final_blk_d;
      first_blk_q <= first_blk_d;
      pad_owed_q  <= pad_owed_d;
      len_lo_q    <= len_lo_d;
    end
  end

  assign in_ready  = (state_q == S_FILL);
  assign blk_valid = (state_q == S_EMIT);
  assign blk_data  = buf_q;
  assign blk_first = first_blk_q;
  assign blk_last  = final_blk_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: hand-computed padded blocks, latency,
// backpressure and mid-message reset.
module tb_sha256_padder;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  int           n_cmp;
  int           n_err;
  logic [511:0] exp_blk;

  sha256_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_first (blk_first),
    .blk_last  (blk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setw(input int i, input logic [31:0] w);
    exp_blk[511-32*i -: 32] = w;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int k;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      chk("send_ready_timeout", 512'(in_ready), 512'(1));
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_blk(input string tag, input logic [511:0] e, input logic ef,
                            input logic el, input int lat, input int hold);
    int k;
    k = 0;
    blk_ready = 1'b0;
    @(negedge clk);
    while (!blk_valid && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!blk_valid) begin
      chk({tag, "_valid_timeout"}, 512'(blk_valid), 512'(1));
      return;
    end
    chk({tag, "_latency"}, 512'(k), 512'(lat));
    chk({tag, "_data"}, blk_data, e);
    chk({tag, "_first"}, 512'(blk_first), 512'(ef));
    chk({tag, "_last"}, 512'(blk_last), 512'(el));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_data"}, blk_data, e);
      chk({tag, "_hold_valid"}, 512'(blk_valid), 512'(1));
      chk({tag, "_hold_in_ready"}, 512'(in_ready), 512'(0));
      chk({tag, "_hold_first"}, 512'(blk_first), 512'(ef));
      chk({tag, "_hold_last"}, 512'(blk_last), 512'(el));
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 512'(in_ready), 512'(1));
    chk({tag, "_blk_valid"}, 512'(blk_valid), 512'(0));
    chk({tag, "_blk_data"}, blk_data, 512'(0));
    chk({tag, "_blk_first"}, 512'(blk_first), 512'(1));
    chk({tag, "_blk_last"}, 512'(blk_last), 512'(0));
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_bytes  = '0;
    blk_ready = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    // "abc": single block, length 24 bits
    exp_blk = '0;
    setw(0, 32'h6162_6380);
    setw(15, 32'h0000_0018);
    send_word(32'h6162_6300, 1'b1, 2'd3);
    expect_blk("abc", exp_blk, 1'b1, 1'b1, 15, 0);

    // 55 bytes: last partial word in slot 13, low byte must be masked
    exp_blk = '0;
    for (int i = 0; i < 13; i++) begin
      send_word(32'h5A00_0000 | 32'(i), 1'b0, 2'd0);
      setw(i, 32'h5A00_0000 | 32'(i));
    end
    send_word(32'hAABB_CCDD, 1'b1, 2'd3);
    setw(13, 32'hAABB_CC80);
    setw(15, 32'h0000_01B8);
    expect_blk("b55", exp_blk, 1'b1, 1'b1, 2, 0);

    // 56 bytes: no room for the length, continuation block carries it
    exp_blk = '0;
    for (int i = 0; i < 14; i++) begin
      send_word(32'hC0DE_0000 + 32'(i), (i == 13), 2'd0);
      setw(i, 32'hC0DE_0000 + 32'(i));
    end
    setw(14, 32'h8000_0000);
    expect_blk("b56a", exp_blk, 1'b1, 1'b0, 2, 0);
    exp_blk = '0;
    setw(15, 32'h0000_01C0);
    expect_blk("b56b", exp_blk, 1'b0, 1'b1, 16, 0);

    // 64 bytes: raw block under 5 cycles of backpressure, then pad-only block
    exp_blk = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'h0F00_0000 + 32'(i), (i == 15), 2'd0);
      setw(i, 32'h0F00_0000 + 32'(i));
    end
    expect_blk("b64a", exp_blk, 1'b1, 1'b0, 0, 5);
    exp_blk = '0;
    setw(0, 32'h8000_0000);
    setw(15, 32'h0000_0200);
    expect_blk("b64b", exp_blk, 1'b0, 1'b1, 16, 0);

    // Next message after a multi-block one starts with first=1
    exp_blk = '0;
    setw(0, 32'h6162_6380);
    setw(15, 32'h0000_0018);
    send_word(32'h6162_6300, 1'b1, 2'd3);
    expect_blk("abc2", exp_blk, 1'b1, 1'b1, 15, 0);

    // Reset after 7 accepted words discards the partial message
    for (int i = 0; i < 7; i++) begin
      send_word(32'h7700_0000 + 32'(i), 1'b0, 2'd0);
    end
    @(negedge clk);
    chk("pre_reset_data_loaded", 512'(blk_data[511:480]), 512'(32'h7700_0000));
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    send_word(32'h6162_6300, 1'b1, 2'd3);
    expect_blk("abc3", exp_blk, 1'b1, 1'b1, 15, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
